spi_bus_arbiter: RTL and testbench
==================================

Name: spi_bus_arbiter

Overview:
- Shares one SPIMaster byte engine between two requesters, A (SD card) and B (SPI flash), each with its own active-low chip select.
- A requester holds its request line high for a multi-byte transaction. The arbiter grants the bus round-robin, frames chip select with setup and hold delays, and forwards byte starts and completions.
- Sits between the CPU-side SPI register blocks and the SPIMaster instance.

Parameters:
CS_SETUP_CYCLES, 2, clocks chip select is low before grant is asserted (0 = grant on the cycle after selection)
CS_HOLD_CYCLES, 2, clocks chip select stays low after the request drops, before release

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
a_req  in  1  requester A wants the bus; held high for the whole transaction
a_grant  out  1  A owns the bus and may start bytes
a_xfer_start  in  1  single-cycle pulse: start one byte for A
a_tx_data  in  8  A byte to send, sampled with a_xfer_start
a_divider  in  9  A SCLK divider, sampled with a_xfer_start
a_xfer_complete  out  1  single-cycle pulse: A byte done
b_req, b_grant, b_xfer_start, b_tx_data, b_divider, b_xfer_complete  same as the A ports, for B
rx_data_in  in  8  received byte from SPIMaster
rx_data  out  8  received byte, valid when either *_xfer_complete is high
cs_n  out  2  chip selects; bit0 = A, bit1 = B; active low
m_xfer_start  out  1  start pulse to SPIMaster
m_tx_data  out  8  byte to SPIMaster, registered
m_divider  out  9  divider to SPIMaster, registered
m_xfer_complete  in  1  completion pulse from SPIMaster

Behaviour:
- Reset values (applied on the clock edge while reset is high): cs_n=2'b11, both grants 0, both completes 0, m_xfer_start 0, m_tx_data 8'hFF, m_divider 0, state IDLE, last_owner=B (so A wins the first tie).
- States: IDLE, SETUP, GRANTED, BUSY, HOLD.
- IDLE:
  - Exactly one req high: select that requester.
  - Both high: select the requester that is not last_owner.
  - On selection: drive the selected cs_n bit low next cycle, record the owner, update last_owner, go to SETUP. With CS_SETUP_CYCLES=0, go straight to GRANTED.
- SETUP:
  - Counts CS_SETUP_CYCLES clocks with cs low, then goes to GRANTED.
  - The owner's grant is registered high on GRANTED entry: grant rises CS_SETUP_CYCLES+1 cycles after req is sampled in IDLE.
- GRANTED:
  - Owner xfer_start high: latch owner tx_data and divider into m_tx_data/m_divider, pulse m_xfer_start for exactly 1 cycle (the following cycle), go to BUSY.
  - Owner req low (and no start): go to HOLD, grant drops.
  - Start and req-low in the same cycle: the start wins.
- BUSY:
  - m_tx_data and m_divider are held stable, because SPIMaster reads them throughout the byte.
  - On m_xfer_complete: the owner's xfer_complete is high in the same cycle (combinational, gated by owner); rx_data=rx_data_in. Return to GRANTED.
- HOLD: cs low for CS_HOLD_CYCLES clocks; then cs_n=2'b11 and go to IDLE. IDLE arbitrates on its first cycle, so cs_n is all-high for at least one cycle between owners.
- Ignored inputs:
  - xfer_start from the non-owner, or from any requester while not in GRANTED: no m_xfer_start, no complete.
  - m_xfer_complete outside BUSY: no output pulse.
- Req dropping during SETUP: grant still asserts on GRANTED entry; the next cycle goes to HOLD.
- Req dropping during BUSY: the byte finishes and its complete pulse is delivered, then GRANTED→HOLD.
- Invariants:
  - At most one cs_n bit low.
  - At most one grant high.
  - A grant is high only while that requester's cs_n bit is low.
- Reset mid-transfer: all outputs return to reset values on the next edge. SPIMaster shares the reset and aborts its byte too.
- Counter width: ceil(log2(max(CS_SETUP_CYCLES, CS_HOLD_CYCLES)+1)), at least 1 bit.

Test Plan:
- Reset, then a_req=1 → cs_n=2'b10 the next cycle; a_grant=1 three cycles after a_req is sampled.
- A granted, a_xfer_start with a_tx_data=8'hA5, a_divider=9'd4 → one m_xfer_start pulse with m_tx_data=A5, m_divider=4, both held until m_xfer_complete. Bench returns rx_data_in=8'h3C → a_xfer_complete pulses once with rx_data=3C; b_xfer_complete stays 0.
- a_req and b_req rise in the same cycle from reset → A served first. A drops req → cs_n=2'b10 for two more cycles after a_grant falls, then 2'b11 for ≥1 cycle, then 2'b01 and b_grant.
- Both requesters hold req across repeated transactions → ownership alternates A, B, A, B; never two grants or two low cs_n bits.
- b_xfer_start pulsed while A owns the bus, and a_xfer_start pulsed during BUSY → no extra m_xfer_start, no spurious complete.
- reset asserted in BUSY mid-byte → next cycle cs_n=2'b11, grants 0, m_tx_data=FF. A later a_req is granted normally after CS_SETUP_CYCLES+1 cycles.

Source files
------------

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPIMaster byte engine between requester A (SD card)
// and requester B (SPI flash), framing each owner's chip select with setup and hold delays.
module spi_bus_arbiter #(
  parameter int unsigned CS_SETUP_CYCLES = 2,
  parameter int unsigned CS_HOLD_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       reset,

  input  logic       a_req,
  output logic       a_grant,
  input  logic       a_xfer_start,
  input  logic [7:0] a_tx_data,
  input  logic [8:0] a_divider,
  output logic       a_xfer_complete,

  input  logic       b_req,
  output logic       b_grant,
  input  logic       b_xfer_start,
  input  logic [7:0] b_tx_data,
  input  logic [8:0] b_divider,
  output logic       b_xfer_complete,

  input  logic [7:0] rx_data_in,
  output logic [7:0] rx_data,
  output logic [1:0] cs_n,

  output logic       m_xfer_start,
  output logic [7:0] m_tx_data,
  output logic [8:0] m_divider,
  input  logic       m_xfer_complete
);

  localparam int unsigned CNT_MAX = (CS_SETUP_CYCLES > CS_HOLD_CYCLES) ? CS_SETUP_CYCLES
                                                                       : CS_HOLD_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam int unsigned SETUP_LAST_I = (CS_SETUP_CYCLES > 0) ? CS_SETUP_CYCLES - 1 : 0;
  localparam int unsigned HOLD_LAST_I  = (CS_HOLD_CYCLES > 0) ? CS_HOLD_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_LAST_I);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_LAST_I);

  // Owner encoding: 0 = A, 1 = B.
  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_GRANTED,
    S_BUSY,
    S_HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             last_owner_q, last_owner_d;
  logic [1:0]       cs_n_q, cs_n_d;
  logic             a_grant_q, a_grant_d;
  logic             b_grant_q, b_grant_d;
  logic             m_start_q, m_start_d;
  logic [7:0]       m_tx_q, m_tx_d;
  logic [8:0]       m_div_q, m_div_d;

  logic             pick;
  logic             own_req;
  logic             own_start;
  logic [7:0]       own_tx;
  logic [8:0]       own_div;
  logic             own_granted;

  // Owner-side views of the requester inputs.
  always_comb begin
    own_req     = (owner_q == OWN_B) ? b_req        : a_req;
    own_start   = (owner_q == OWN_B) ? b_xfer_start : a_xfer_start;
    own_tx      = (owner_q == OWN_B) ? b_tx_data    : a_tx_data;
    own_div     = (owner_q == OWN_B) ? b_divider    : a_divider;
    own_granted = a_grant_q | b_grant_q;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cs_n_d       = cs_n_q;
    a_grant_d    = a_grant_q;
    b_grant_d    = b_grant_q;
    m_start_d    = 1'b0;
    m_tx_d       = m_tx_q;
    m_div_d      = m_div_q;
    pick         = OWN_A;

    case (state_q)
      S_IDLE: begin
        if (a_req || b_req) begin
          // On a tie the requester that did not own the bus last time wins.
          pick         = (a_req && b_req) ? ~last_owner_q : b_req;
          owner_d      = pick;
          last_owner_d = pick;
          cs_n_d       = (pick == OWN_B) ? 2'b01 : 2'b10;
          cnt_d        = '0;
          state_d      = (CS_SETUP_CYCLES == 0) ? S_GRANTED : S_SETUP;
        end
      end

      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = S_GRANTED;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_GRANTED: begin
        // The first GRANTED cycle only raises the grant; the owner acts once it sees it.
        if (!own_granted) begin
          a_grant_d = (owner_q == OWN_A);
          b_grant_d = (owner_q == OWN_B);
        end else if (own_start) begin
          m_start_d = 1'b1;
          m_tx_d    = own_tx;
          m_div_d   = own_div;
          state_d   = S_BUSY;
        end else if (!own_req) begin
          a_grant_d = 1'b0;
          b_grant_d = 1'b0;
          cnt_d     = '0;
          if (CS_HOLD_CYCLES == 0) begin
            cs_n_d  = 2'b11;
            state_d = S_IDLE;
          end else begin
            state_d = S_HOLD;
          end
        end
      end

      S_BUSY: begin
        if (m_xfer_complete) begin
          state_d = S_GRANTED;
        end
      end

      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cs_n_d  = 2'b11;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d   = S_IDLE;
        cs_n_d    = 2'b11;
        a_grant_d = 1'b0;
        b_grant_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      owner_q      <= OWN_A;
      last_owner_q <= OWN_B;
      cs_n_q       <= 2'b11;
      a_grant_q    <= 1'b0;
      b_grant_q    <= 1'b0;
      m_start_q    <= 1'b0;
      m_tx_q       <= 8'hFF;
      m_div_q      <= 9'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cs_n_q       <= cs_n_d;
      a_grant_q    <= a_grant_d;
      b_grant_q    <= b_grant_d;
      m_start_q    <= m_start_d;
      m_tx_q       <= m_tx_d;
      m_div_q      <= m_div_d;
    end
  end

  // Completion is forwarded in the same cycle, only to the owner of the byte in flight.
  always_comb begin
    a_xfer_complete = (state_q == S_BUSY) && m_xfer_complete && (owner_q == OWN_A);
    b_xfer_complete = (state_q == S_BUSY) && m_xfer_complete && (owner_q == OWN_B);
    rx_data         = rx_data_in;
  end

  assign a_grant      = a_grant_q;
  assign b_grant      = b_grant_q;
  assign cs_n         = cs_n_q;
  assign m_xfer_start = m_start_q;
  assign m_tx_data    = m_tx_q;
  assign m_divider    = m_div_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: directed protocol steps, then two randomized requesters
// and an SPIMaster responder checked against a transaction-level arbitration model.
module tb_spi_bus_arbiter;

  logic       clk;
  logic       reset;
  logic       a_req, a_grant, a_xfer_start, a_xfer_complete;
  logic [7:0] a_tx_data;
  logic [8:0] a_divider;
  logic       b_req, b_grant, b_xfer_start, b_xfer_complete;
  logic [7:0] b_tx_data;
  logic [8:0] b_divider;
  logic [7:0] rx_data_in, rx_data;
  logic [1:0] cs_n;
  logic       m_xfer_start;
  logic [7:0] m_tx_data;
  logic [8:0] m_divider;
  logic       m_xfer_complete;

  spi_bus_arbiter #(.CS_SETUP_CYCLES(2), .CS_HOLD_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_grant(a_grant), .a_xfer_start(a_xfer_start),
    .a_tx_data(a_tx_data), .a_divider(a_divider), .a_xfer_complete(a_xfer_complete),
    .b_req(b_req), .b_grant(b_grant), .b_xfer_start(b_xfer_start),
    .b_tx_data(b_tx_data), .b_divider(b_divider), .b_xfer_complete(b_xfer_complete),
    .rx_data_in(rx_data_in), .rx_data(rx_data), .cs_n(cs_n),
    .m_xfer_start(m_xfer_start), .m_tx_data(m_tx_data), .m_divider(m_divider),
    .m_xfer_complete(m_xfer_complete)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cs"}, 32'(cs_n), 32'h3);
    chk({tag, "_ag"}, 32'(a_grant), 32'h0);
    chk({tag, "_bg"}, 32'(b_grant), 32'h0);
    chk({tag, "_mst"}, 32'(m_xfer_start), 32'h0);
    chk({tag, "_mtx"}, 32'(m_tx_data), 32'hFF);
    chk({tag, "_mdiv"}, 32'(m_divider), 32'h0);
  endtask

  // Randomized-phase model state (index 0 = A, 1 = B)
  int         cyc;
  bit         req[2];
  int         req_since[2];
  int         bytes_left[2];
  bit         in_byte[2];
  int         idle_wait[2];
  int         wait_cnt[2];
  int         txn_done[2];
  bit         st[2];
  logic [7:0] txv[2];
  logic [8:0] dvv[2];
  bit         g[2];
  bit         prev_grant[2];
  logic [1:0] cs, prev_cs;
  int         cs_low_start;
  int         last_owner;
  bit         hold_track;
  int         hold_bit;
  int         hold_cnt;
  bit         exp_mstart;
  logic [7:0] exp_tx;
  logic [8:0] exp_div;
  bit         byte_active;
  int         byte_owner;
  int         resp_delay;
  bit         comp_now;
  int         comp_owner;
  logic [7:0] rx_val;
  bit         mc;

  initial begin
    reset = 1'b1;
    a_req = 0; a_xfer_start = 0; a_tx_data = 0; a_divider = 0;
    b_req = 0; b_xfer_start = 0; b_tx_data = 0; b_divider = 0;
    rx_data_in = 0; m_xfer_complete = 0;
    tick; tick;
    chk_reset_outputs("rst");
    #1 chk("rst_acomp", 32'(a_xfer_complete), 0);
    chk("rst_bcomp", 32'(b_xfer_complete), 0);

    // Single requester A: chip select next cycle, grant three cycles after sampling
    reset = 0; a_req = 1;
    tick; chk("a_sel_cs", 32'(cs_n), 32'h2); chk("a_setup_g0", 32'(a_grant), 0);
    tick; chk("a_setup_g1", 32'(a_grant), 0);
    tick; chk("a_setup_g2", 32'(a_grant), 0);
    tick; chk("a_grant", 32'(a_grant), 1); chk("a_grant_b", 32'(b_grant), 0);

    // One byte for A, inputs changed after the start to prove the latch
    a_xfer_start = 1; a_tx_data = 8'hA5; a_divider = 9'd4;
    tick; chk("a_mst", 32'(m_xfer_start), 1); chk("a_mtx", 32'(m_tx_data), 32'hA5);
    chk("a_mdiv", 32'(m_divider), 4);
    a_xfer_start = 0; a_tx_data = 8'h00; a_divider = 9'd0;
    b_xfer_start = 1;
    tick; chk("a_mst_pulse", 32'(m_xfer_start), 0); chk("a_mtx_hold", 32'(m_tx_data), 32'hA5);
    b_xfer_start = 0; a_xfer_start = 1;
    tick; chk("busy_ign_mst", 32'(m_xfer_start), 0); chk("a_mdiv_hold", 32'(m_divider), 4);
    a_xfer_start = 0;
    tick; chk("busy_ign_mst2", 32'(m_xfer_start), 0);
    m_xfer_complete = 1; rx_data_in = 8'h3C;
    #1 chk("a_comp", 32'(a_xfer_complete), 1); chk("a_comp_b", 32'(b_xfer_complete), 0);
    chk("a_rx", 32'(rx_data), 32'h3C);
    tick; m_xfer_complete = 0;
    #1 chk("a_comp_once", 32'(a_xfer_complete), 0);

    // Back in GRANTED: non-owner start and a stray completion are ignored
    b_xfer_start = 1;
    tick; b_xfer_start = 0; m_xfer_complete = 1;
    chk("b_start_ign", 32'(m_xfer_start), 0); chk("a_still_g", 32'(a_grant), 1);
    #1 chk("stray_comp_a", 32'(a_xfer_complete), 0); chk("stray_comp_b", 32'(b_xfer_complete), 0);
    tick; m_xfer_complete = 0;
    chk("stray_mst", 32'(m_xfer_start), 0);

    // A releases: hold two cycles then chip select high
    a_req = 0;
    tick; chk("a_rel_g", 32'(a_grant), 0); chk("a_hold_cs0", 32'(cs_n), 32'h2);
    tick; chk("a_hold_cs1", 32'(cs_n), 32'h2);
    tick; chk("a_rel_cs", 32'(cs_n), 32'h3);
    tick; chk("idle_cs", 32'(cs_n), 32'h3);

    // Simultaneous requests from reset: A first, then B after the gap
    reset = 1;
    tick; reset = 0; a_req = 1; b_req = 1;
    tick; chk("tie_cs_a", 32'(cs_n), 32'h2);
    tick; tick;
    tick; chk("tie_ag", 32'(a_grant), 1); chk("tie_bg0", 32'(b_grant), 0);
    a_req = 0;
    tick; chk("tie_ag_drop", 32'(a_grant), 0); chk("tie_hold0", 32'(cs_n), 32'h2);
    tick; chk("tie_hold1", 32'(cs_n), 32'h2);
    tick; chk("tie_gap", 32'(cs_n), 32'h3);
    tick; chk("tie_cs_b", 32'(cs_n), 32'h1); chk("tie_bg_early", 32'(b_grant), 0);
    tick; tick;
    tick; chk("tie_bg", 32'(b_grant), 1); chk("tie_ag_off", 32'(a_grant), 0);

    // Reset during B's byte
    b_xfer_start = 1; b_tx_data = 8'h5A; b_divider = 9'h1FF;
    tick; chk("b_mst", 32'(m_xfer_start), 1); chk("b_mtx", 32'(m_tx_data), 32'h5A);
    chk("b_mdiv", 32'(m_divider), 32'h1FF);
    b_xfer_start = 0;
    tick; reset = 1;
    tick; chk_reset_outputs("midrst");
    reset = 0; b_req = 0; a_req = 1;
    tick; chk("post_rst_cs", 32'(cs_n), 32'h2);
    tick; tick; chk("post_rst_g0", 32'(a_grant), 0);
    tick; chk("post_rst_g", 32'(a_grant), 1);
    a_req = 0;
    tick; tick; tick; tick;

    // Randomized traffic from both requesters
    reset = 1; tick; tick; reset = 0;
    cyc = 0; prev_cs = 2'b11; cs_low_start = -100; last_owner = 1;
    hold_track = 0; hold_bit = 0; hold_cnt = 0;
    exp_mstart = 0; exp_tx = 0; exp_div = 0; byte_active = 0; byte_owner = 0;
    resp_delay = 0; comp_now = 0; comp_owner = 0; rx_val = 0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 0; req_since[i] = 0; bytes_left[i] = 0; in_byte[i] = 0;
      idle_wait[i] = 0; wait_cnt[i] = 0; txn_done[i] = 0; prev_grant[i] = 0;
    end

    for (int n = 0; n < 3000; n++) begin
      tick; cyc++;
      g[0] = a_grant; g[1] = b_grant; cs = cs_n;
      chk("inv_cs", 32'(cs != 2'b00), 1);
      chk("inv_grant", 32'(g[0] & g[1]), 0);
      chk("inv_grant_cs", 32'((g[0] & cs[0]) | (g[1] & cs[1])), 0);
      chk("rnd_mst", 32'(m_xfer_start), 32'(exp_mstart));
      if (exp_mstart) begin
        byte_active = 1; resp_delay = $urandom_range(2, 5); exp_mstart = 0;
      end
      if (byte_active) begin
        chk("rnd_mtx", 32'(m_tx_data), 32'(exp_tx));
        chk("rnd_mdiv", 32'(m_divider), 32'(exp_div));
      end
      if (prev_cs == 2'b11 && cs != 2'b11) cs_low_start = cyc;
      if (prev_cs != 2'b11 && cs != 2'b11) chk("cs_switch", 32'(cs), 32'(prev_cs));
      for (int i = 0; i < 2; i++) begin
        if (g[i] && !prev_grant[i]) begin
          // Requests visible at selection were driven four observations before the grant
          bit si, so;
          int exp_own;
          si = req[i] && (req_since[i] <= cyc - 4);
          so = req[1-i] && (req_since[1-i] <= cyc - 4);
          if (si && so) exp_own = 1 - last_owner;
          else if (si) exp_own = i;
          else if (so) exp_own = 1 - i;
          else exp_own = 2;
          chk("rr_owner", 32'(i), 32'(exp_own));
          chk("grant_latency", 32'(cyc - cs_low_start), 3);
          last_owner = i;
          wait_cnt[i] = 0;
        end
        if (!g[i] && prev_grant[i]) begin
          hold_track = 1; hold_bit = i; hold_cnt = 0;
        end
      end
      if (hold_track) begin
        if (cs[hold_bit] == 1'b0) hold_cnt++;
        else begin
          chk("hold_len", 32'(hold_cnt), 2);
          hold_track = 0;
        end
      end
      prev_cs = cs; prev_grant[0] = g[0]; prev_grant[1] = g[1];

      comp_now = 0; mc = 0;
      for (int i = 0; i < 2; i++) begin
        st[i] = 0; txv[i] = 8'($urandom); dvv[i] = 9'($urandom);
        if (!req[i]) begin
          if (idle_wait[i] > 0) idle_wait[i]--;
          else if (!in_byte[i] && !g[i] && $urandom_range(0, 3) == 0) begin
            req[i] = 1; req_since[i] = cyc; bytes_left[i] = $urandom_range(0, 4); wait_cnt[i] = 0;
          end else if (!in_byte[i] && !g[i] && $urandom_range(0, 9) == 0) st[i] = 1;
        end else if (!g[i]) begin
          wait_cnt[i]++;
          if (wait_cnt[i] > 150) begin
            chk("grant_timeout", 32'(wait_cnt[i]), 150);
            wait_cnt[i] = 0;
          end
        end else if (in_byte[i]) begin
          if ($urandom_range(0, 4) == 0) st[i] = 1;
        end else if (bytes_left[i] > 0) begin
          st[i] = 1; exp_mstart = 1; exp_tx = txv[i]; exp_div = dvv[i];
          byte_owner = i; in_byte[i] = 1; bytes_left[i]--;
          if (bytes_left[i] == 0 && $urandom_range(0, 1) == 1) begin
            req[i] = 0; txn_done[i]++; idle_wait[i] = $urandom_range(0, 10);
          end
        end else begin
          req[i] = 0; txn_done[i]++; idle_wait[i] = $urandom_range(0, 10);
        end
      end
      if (byte_active) begin
        resp_delay--;
        if (resp_delay == 0) begin
          mc = 1; rx_val = 8'($urandom); comp_now = 1; comp_owner = byte_owner;
          byte_active = 0; in_byte[byte_owner] = 0;
        end
      end else if ($urandom_range(0, 9) == 0) mc = 1;

      a_req = req[0]; a_xfer_start = st[0]; a_tx_data = txv[0]; a_divider = dvv[0];
      b_req = req[1]; b_xfer_start = st[1]; b_tx_data = txv[1]; b_divider = dvv[1];
      m_xfer_complete = mc; rx_data_in = comp_now ? rx_val : 8'($urandom);
      #1;
      chk("rnd_acomp", 32'(a_xfer_complete), 32'(comp_now && comp_owner == 0));
      chk("rnd_bcomp", 32'(b_xfer_complete), 32'(comp_now && comp_owner == 1));
      if (comp_now) chk("rnd_rx", 32'(rx_data), 32'(rx_val));
    end
    chk("progress_a", 32'(txn_done[0] >= 10), 1);
    chk("progress_b", 32'(txn_done[1] >= 10), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
